// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and block memory.
// Hits complete in the request cycle; misses stall via BUSYWAIT while writeback/refill run.
module dcache_controller #(
    parameter int unsigned LINES = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MEMREAD,
    input  logic         MEMWRITE,
    input  logic [2:0]   FUNCT3,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int unsigned IDX = $clog2(LINES);
    localparam int unsigned TAG = 28 - IDX;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG-1:0]   r_tag  [LINES];
    logic [127:0]     r_data [LINES];

    logic [IDX-1:0] w_index;
    logic [TAG-1:0] w_tag_in;
    logic [1:0]     w_word_off;
    logic [1:0]     w_byte_off;
    logic [127:0]   w_line;
    logic [31:0]    w_word;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic           w_hit;
    logic           w_req;
    logic [31:0]    w_merged;
    logic [31:0]    w_load;

    logic           w_mem_read_nxt;
    logic           w_mem_write_nxt;
    logic [27:0]    w_mem_addr_nxt;
    logic [127:0]   w_mem_wdata_nxt;

    assign w_index    = ADDRESS[4 +: IDX];
    assign w_tag_in   = ADDRESS[31 -: TAG];
    assign w_word_off = ADDRESS[3:2];
    assign w_byte_off = ADDRESS[1:0];
    assign w_line     = r_data[w_index];
    assign w_word     = w_line[{w_word_off, 5'b0} +: 32];
    assign w_byte     = w_word[{w_byte_off, 3'b0} +: 8];
    assign w_half     = w_word[{ADDRESS[1], 4'b0} +: 16];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag_in);
    assign w_req      = MEMREAD | MEMWRITE;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit)
                    w_next_state = r_dirty[w_index] ? S_WRITEBACK : S_ALLOCATE;
            end
            S_WRITEBACK: if (!MEM_BUSYWAIT) w_next_state = S_ALLOCATE;
            S_ALLOCATE:  if (!MEM_BUSYWAIT) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Outputs: memory strobes are precomputed from the next state and registered
    always_comb begin
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_mem_addr_nxt  = 28'h0;
        w_mem_wdata_nxt = 128'h0;
        BUSYWAIT        = 1'b0;
        case (w_next_state)
            S_WRITEBACK: begin
                w_mem_write_nxt = 1'b1;
                w_mem_addr_nxt  = {r_tag[w_index], w_index};
                w_mem_wdata_nxt = w_line;
            end
            S_ALLOCATE: begin
                w_mem_read_nxt = 1'b1;
                w_mem_addr_nxt = ADDRESS[31:4];
            end
            default: ;
        endcase
        if (!RESET)
            BUSYWAIT = (r_state == S_IDLE) ? (w_req && !w_hit) : 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= 28'h0;
            MEM_WRITEDATA <= 128'h0;
        end else begin
            MEM_READ      <= w_mem_read_nxt;
            MEM_WRITE     <= w_mem_write_nxt;
            MEM_ADDRESS   <= w_mem_addr_nxt;
            MEM_WRITEDATA <= w_mem_wdata_nxt;
        end
    end

    // Load extraction and store lane merge; FUNCT3[1:0] picks size, FUNCT3[2] picks zero-extend
    always_comb begin
        w_load   = w_word;
        w_merged = w_word;
        case (FUNCT3[1:0])
            2'b00: begin
                w_load = FUNCT3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_merged[{w_byte_off, 3'b0} +: 8] = WRITEDATA[7:0];
            end
            2'b01: begin
                w_load = FUNCT3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                w_merged[{ADDRESS[1], 4'b0} +: 16] = WRITEDATA[15:0];
            end
            default: begin
                w_load   = w_word;
                w_merged = WRITEDATA;
            end
        endcase
        READDATA = (MEMREAD && !RESET) ? w_load : 32'h0;
    end

    // Line storage: refill on allocate completion, lane merge on store hit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == S_ALLOCATE && !MEM_BUSYWAIT) begin
            r_data[w_index]  <= MEM_READDATA;
            r_tag[w_index]   <= w_tag_in;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (r_state == S_IDLE && MEMWRITE && w_hit) begin
            r_data[w_index][{w_word_off, 5'b0} +: 32] <= w_merged;
            r_dirty[w_index] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory responder.
module tb_dcache_controller;
    logic         CLK = 1'b0;
    logic         RESET;
    logic         MEMREAD;
    logic         MEMWRITE;
    logic [2:0]   FUNCT3;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    localparam int LAT = 3;

    int n_cmp = 0;
    int n_err = 0;
    int mem_cnt = 0;

    int           busy_n;
    logic         saw_rd, saw_wr, saw_both;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;

    dcache_controller #(.LINES(8)) dut (
        .CLK(CLK), .RESET(RESET), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory completes a request in its LAT-th cycle; block b word k = (k+1)<<28 + b
    always @(posedge CLK) begin
        if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
        else                                         mem_cnt <= 0;
    end
    assign MEM_BUSYWAIT = !((MEM_READ || MEM_WRITE) && mem_cnt == LAT - 1);
    assign MEM_READDATA = {32'h4000_0000 + {4'h0, MEM_ADDRESS}, 32'h3000_0000 + {4'h0, MEM_ADDRESS},
                           32'h2000_0000 + {4'h0, MEM_ADDRESS}, 32'h1000_0000 + {4'h0, MEM_ADDRESS}};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        @(posedge CLK); #1;
        MEMREAD = rd; MEMWRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITEDATA = wd;
        @(negedge CLK);
    endtask

    task automatic wait_done();
        busy_n = 0; saw_rd = 0; saw_wr = 0; saw_both = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (BUSYWAIT === 1'b1 && busy_n < 50) begin
            if (MEM_READ && MEM_WRITE) saw_both = 1;
            if (MEM_READ && !saw_rd) begin saw_rd = 1; rd_addr = MEM_ADDRESS; end
            if (MEM_WRITE && !saw_wr) begin saw_wr = 1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA; end
            busy_n++;
            @(negedge CLK);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1; MEMREAD = 1; MEMWRITE = 0; FUNCT3 = 3'b010; ADDRESS = 32'h40; WRITEDATA = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_readdata", READDATA, 0);
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_mem_address", MEM_ADDRESS, 0);
        check("rst_mem_writedata", MEM_WRITEDATA, 0);

        @(posedge CLK); #1; RESET = 0; MEMREAD = 0;
        @(negedge CLK);
        check("idle_busywait", BUSYWAIT, 0);
        check("idle_readdata", READDATA, 0);

        // Clean miss on 0x40
        req(1, 0, 3'b010, 32'h40, 0);
        check("miss_first_busy", BUSYWAIT, 1);
        check("miss_first_mem_read", MEM_READ, 0);
        wait_done();
        check("clean_stall", busy_n, 4);
        check("clean_saw_read", saw_rd, 1);
        check("clean_read_addr", rd_addr, 28'h4);
        check("clean_no_write", saw_wr, 0);
        check("refill_word0", READDATA, 32'h1000_0004);

        req(1, 0, 3'b010, 32'h44, 0);
        check("hit_busy", BUSYWAIT, 0);
        check("hit_word1", READDATA, 32'h2000_0004);

        // Byte and halfword stores / loads
        req(0, 1, 3'b000, 32'h43, 32'h1234_56A5);
        check("sb_busy", BUSYWAIT, 0);
        req(1, 0, 3'b000, 32'h43, 0);
        check("lb_43", READDATA, 32'hFFFF_FFA5);
        req(1, 0, 3'b100, 32'h43, 0);
        check("lbu_43", READDATA, 32'h0000_00A5);
        req(0, 1, 3'b001, 32'h42, 32'hFFFF_8001);
        check("sh_busy", BUSYWAIT, 0);
        req(1, 0, 3'b001, 32'h42, 0);
        check("lh_42", READDATA, 32'hFFFF_8001);
        req(1, 0, 3'b101, 32'h42, 0);
        check("lhu_42", READDATA, 32'h0000_8001);
        req(1, 0, 3'b010, 32'h40, 0);
        check("lw_40_merged", READDATA, 32'h8001_0004);
        req(1, 0, 3'b001, 32'h41, 0);
        check("lh_41_low", READDATA, 32'h0000_0004);
        req(1, 0, 3'b000, 32'h40, 0);
        check("lb_40", READDATA, 32'h0000_0004);
        req(1, 0, 3'b011, 32'h43, 0);
        check("undef_f3_word", READDATA, 32'h8001_0004);
        req(0, 0, 3'b010, 32'h40, 0);
        check("no_read_zero", READDATA, 0);

        // Dirty conflict at index 4: writeback old block then refill
        req(1, 0, 3'b010, 32'hC0, 0);
        wait_done();
        check("dirty_stall", busy_n, 7);
        check("dirty_never_both", saw_both, 0);
        check("dirty_saw_write", saw_wr, 1);
        check("dirty_wb_addr", wr_addr, 28'h4);
        check("dirty_wb_data", wr_data, {32'h4000_0004, 32'h3000_0004, 32'h2000_0004, 32'h8001_0004});
        check("dirty_refill_addr", rd_addr, 28'hC);
        check("dirty_refill_word0", READDATA, 32'h1000_000C);

        // Simultaneous read+write behaves as a store
        req(1, 1, 3'b010, 32'hC4, 32'hDEAD_BEEF);
        check("rw_store_busy", BUSYWAIT, 0);
        req(1, 0, 3'b010, 32'hC4, 0);
        check("rw_store_readback", READDATA, 32'hDEAD_BEEF);

        // Reset during allocate abandons the refill and invalidates lines
        req(1, 0, 3'b010, 32'h100, 0);
        check("rstmiss_busy", BUSYWAIT, 1);
        @(negedge CLK);
        check("rstmiss_mem_read", MEM_READ, 1);
        check("rstmiss_addr", MEM_ADDRESS, 28'h10);
        @(posedge CLK); #1; RESET = 1;
        @(negedge CLK);
        check("rstmiss_busy_in_reset", BUSYWAIT, 0);
        @(negedge CLK);
        check("rstmiss_read_dropped", MEM_READ, 0);
        check("rstmiss_busy_after", BUSYWAIT, 0);
        @(posedge CLK); #1; RESET = 0;
        @(negedge CLK);
        check("rstmiss_remiss", BUSYWAIT, 1);
        wait_done();
        check("rstmiss_stall", busy_n, 4);
        check("rstmiss_word0", READDATA, 32'h1000_0010);

        // Dirty store to 0xC4 was lost: clean miss with no writeback
        req(1, 0, 3'b010, 32'hC4, 0);
        check("lost_miss_busy", BUSYWAIT, 1);
        wait_done();
        check("lost_stall", busy_n, 4);
        check("lost_no_write", saw_wr, 0);
        check("lost_word1", READDATA, 32'h2000_000C);

        req(0, 0, 3'b010, 32'h0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache between the CPU's MEM stage (EX_MEM outputs) and a slow block-oriented main data memory. It replaces the direct `data_memory` connection. It serves byte, halfword and word loads and stores selected by FUNCT3. It raises BUSYWAIT to stall the pipeline on a miss while it writes back a dirty victim and refills the line.

## Interface
Parameters:
- LINES, 8: number of cache lines; power of two, ≥2. IDX = log2(LINES), TAG = 28 − IDX.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  reset, synchronous, active-high
- MEMREAD  in  1  CPU load request (from EX_MEM)
- MEMWRITE  in  1  CPU store request (from EX_MEM)
- FUNCT3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ADDRESS  in  32  byte address (ALURESULT_EXOUT)
- WRITEDATA  in  32  store data (DATA2_EXOUT)
- READDATA  out  32  load data, sign/zero-extended per FUNCT3
- BUSYWAIT  out  1  stall request to all pipeline registers and PC
- MEM_READ  out  1  block read request to main memory
- MEM_WRITE  out  1  block write request to main memory
- MEM_ADDRESS  out  28  block address (byte address [31:4])
- MEM_WRITEDATA  out  128  victim block, word 0 in [31:0]
- MEM_READDATA  in  128  refill block, word 0 in [31:0]
- MEM_BUSYWAIT  in  1  main memory busy; low in the cycle a request completes

## Operation
- Address split: byte offset [1:0], word offset [3:2], index [4+IDX−1:4], tag [31:4+IDX].
- Per line: valid, dirty, tag, 4×32-bit data. Hit = valid & tag match.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
  - IDLE:
    - Request present and hit: complete the access.
    - Request present, miss, line dirty: go to WRITEBACK.
    - Request present, miss, line clean: go to ALLOCATE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line data. On the edge where MEM_BUSYWAIT=0, go to ALLOCATE.
  - ALLOCATE: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4]. On the edge where MEM_BUSYWAIT=0:
    - Write MEM_READDATA into the line.
    - Set valid=1, dirty=0 and load the tag.
    - Go to IDLE. The request then hits and completes.
- BUSYWAIT is combinational:
  - In IDLE, BUSYWAIT = (MEMREAD|MEMWRITE) & ~hit.
  - In WRITEBACK and ALLOCATE, BUSYWAIT = 1.
  - BUSYWAIT = 0 while RESET=1.
- Read hit, READDATA (combinational):
  - W: full word; ADDRESS[1:0] ignored.
  - H/HU: halfword selected by ADDRESS[1], sign- or zero-extended; ADDRESS[0] ignored.
  - B/BU: byte selected by ADDRESS[1:0], sign- or zero-extended.
  - READDATA = 0 when MEMREAD=0.
- Write hit: on the edge, merge the lanes selected by the same rules as loads (SB lane ADDRESS[1:0], SH lane ADDRESS[1], SW full word) and set dirty=1.
- MEMREAD and MEMWRITE both high: treated as a store.
- Undefined FUNCT3 (011, 110, 111): treated as W.
- The CPU holds MEMREAD, MEMWRITE, ADDRESS, WRITEDATA and FUNCT3 stable while BUSYWAIT=1.

## Timing
- Reset values:
  - state=IDLE; all valid and dirty bits cleared.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - BUSYWAIT=0, READDATA=0.
- Reset mid-miss: abandons the transaction at that edge; strobes low from the next cycle; dirty data is lost.
- Hit: zero stall cycles. Load data is valid in the request cycle. Store commits at the end of that cycle.
- Clean miss: BUSYWAIT high from the request cycle through the ALLOCATE completion edge, then low in the following IDLE hit cycle. Stall = Tmem + 1 cycles, where Tmem is the number of ALLOCATE cycles including the completion cycle.
- Dirty miss: stall = Twb + Tmem + 1 cycles.
- MEM_READ and MEM_WRITE are registered off the state. They are never high together, and each holds stable until its completion edge.
- MEM_BUSYWAIT is ignored in IDLE.
- Same-index conflict back-to-back: the second request sees the updated tag, no bypass needed.

## Test plan
- Reset, then LW 0x0000_0040 with memory latency 3 → BUSYWAIT high 4 cycles, MEM_READ with MEM_ADDRESS=0x0000004; READDATA = refill word 0 in the completing cycle.
- LW 0x44 right after the refill → hit, BUSYWAIT stays 0, READDATA = refill word 1.
- SB 0xA5 to 0x43, then LB 0x43 → 0xFFFF_FFA5. LBU 0x43 → 0x0000_00A5.
- SH 0x8001 to 0x42, then LH 0x42 → 0xFFFF_8001 and LHU 0x42 → 0x0000_8001; LW 0x40 → upper halfword 0x8001, lower halfword unchanged.
- Dirty line at index 4 (tag A), then LW to same index with tag B → MEM_WRITE with the old block and address {A,4}, then MEM_READ with {B,4}; never both high; BUSYWAIT high throughout.
- Assert RESET during ALLOCATE → next cycle MEM_READ=0, BUSYWAIT=0; a subsequent load to the same address misses again (valid cleared).
